bf16_mul_result_fifo: RTL

BF16_MUL_RESULT_FIFO -- requirements
Module: bf16_mul_result_fifo

---
 rtl/bf16_mul_result_fifo.sv | 117 +++++++++++
 1 files changed

// File: rtl/bf16_mul_result_fifo.sv
// BF16 multiplier result buffer: first-word-fall-through FIFO with credit-based
// issue control. Upstream may start a multiply only while issue_ok is high, so
// every result already in flight is guaranteed a slot when it arrives.
// Optional build macro: BF16_RESULT_FLAGS_EN stores a {nan, inf, zero} class
// alongside each entry; without it m_flags is tied low and no flag storage exists.
module bf16_mul_result_fifo #(
  parameter int DEPTH   = 8,
  parameter int MUL_LAT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_req,
  output logic                     issue_ok,
  input  logic [15:0]              z_in,
  input  logic                     z_in_stb,
  output logic [15:0]              m_data,
  output logic [2:0]               m_flags,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  // Inflight counter has to hold 0..MUL_LAT+1.
  localparam int IW = $clog2(MUL_LAT + 2);
  localparam int SW = ((LW > IW) ? LW : IW) + 1;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [IW-1:0] r_inflight;
  logic          r_overflow;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [SW-1:0] w_credit_sum;

  assign w_full = (r_level == LW'(DEPTH));
  assign w_pop  = (r_level != '0) && m_ready;
  // A full buffer still accepts a result when the head leaves in the same cycle.
  assign w_push = z_in_stb && (!w_full || w_pop);
  assign w_drop = z_in_stb && w_full && !w_pop;

  // Pointer, occupancy and sticky overflow tracking; DEPTH is a power of two so
  // pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Data storage; no reset needed because m_data is masked while empty.
  always_ff @(posedge clk) begin
    if (rst && w_push) r_mem[r_wr_ptr] <= z_in;
  end

  // Results issued but not yet returned; saturates at both ends so a stray
  // strobe never wraps the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inflight <= '0;
    end else begin
      case ({issue_req, z_in_stb})
        2'b10: if (r_inflight < IW'(MUL_LAT + 1)) r_inflight <= r_inflight + IW'(1);
        2'b01: if (r_inflight != '0) r_inflight <= r_inflight - IW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

`ifdef BF16_RESULT_FLAGS_EN
  logic [2:0] r_flg [DEPTH];
  logic [2:0] w_z_flags;

  // Classify the incoming product: {nan, inf, zero}.
  always_comb begin
    w_z_flags    = 3'b000;
    w_z_flags[2] = (z_in[14:7] == 8'hFF) && (z_in[6:0] != 7'd0);
    w_z_flags[1] = (z_in[14:7] == 8'hFF) && (z_in[6:0] == 7'd0);
    w_z_flags[0] = (z_in[14:7] == 8'h00);
  end

  // Flag storage written alongside the data entry.
  always_ff @(posedge clk) begin
    if (rst && w_push) r_flg[r_wr_ptr] <= w_z_flags;
  end

  assign m_flags = m_valid ? r_flg[r_rd_ptr] : 3'b000;
`else
  assign m_flags = 3'b000;
`endif

  assign w_credit_sum = SW'(r_level) + SW'(r_inflight);
  assign issue_ok     = (w_credit_sum < SW'(DEPTH));
  assign m_valid      = (r_level != '0);
  assign m_data       = m_valid ? r_mem[r_rd_ptr] : 16'h0000;
  assign level        = r_level;
  assign overflow     = r_overflow;

endmodule
